// File: rtl/vect_store_serializer_pkg.sv
// Shared types for the vector store path: lane geometry, address width and FSM state names.
package vect_pkg;
  localparam int LANE_W = 24;
  localparam int LANES  = 6;
  localparam int ADDR_W = 16;
  localparam int LIDX_W = 3;

  typedef logic [LANE_W-1:0]       lane_t;
  typedef logic [LANES*LANE_W-1:0] vec_t;
  typedef logic [ADDR_W-1:0]       addr_t;
  typedef logic [LANES-1:0]        mask_t;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} st_e;
endpackage

// File: rtl/vect_store_serializer_if.sv
// Vector-in / memory-write bundle between the ALU result stage, the serializer and data memory.
interface vect_store_serializer_if;
  logic              in_valid;
  logic              in_ready;
  vect_pkg::vec_t    in_data;
  vect_pkg::addr_t   in_addr;
  vect_pkg::mask_t   in_mask;
  logic              mem_we;
  vect_pkg::addr_t   mem_addr;
  vect_pkg::lane_t   mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  in_valid, in_data, in_addr, in_mask, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport master (
    output in_valid, in_data, in_addr, in_mask, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/vect_store_serializer_lane_prio_enc.sv
// Lowest-set-bit encoder over the lane mask; o_any flags a non-empty mask.
module lane_prio_enc
  import vect_pkg::*;
(
  input  mask_t             i_vec,
  output logic [LIDX_W-1:0] o_idx,
  output logic              o_any
);
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = i[LIDX_W-1:0];
    end
  end
endmodule

// File: rtl/vect_store_serializer.sv
// Serialises the enabled lanes of one ALU result vector into single-lane memory writes.
//   state   | meaning
//   IDLE    | ready for a new vector
//   WRITE   | a lane write is being presented to memory
//   DONE    | one-cycle completion pulse
module vect_store_serializer
  import vect_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  vect_store_serializer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]        r_state;
  vec_t              r_data;
  addr_t             r_base;
  mask_t             r_rem;
  logic              r_mem_we;
  addr_t             r_mem_addr;
  lane_t             r_mem_wdata;

  logic              w_idle;
  logic              w_hs;
  logic              w_any;
  logic [LIDX_W-1:0] w_lane;
  mask_t             w_rem_clr;
  mask_t             w_enc_in;
  vec_t              w_src_data;
  addr_t             w_src_base;
  lane_t             w_lane_data;
  addr_t             w_lane_addr;

  assign w_idle    = (r_state == S_IDLE);
  assign w_hs      = r_mem_we && bus.mem_ready;
  // rem & (rem-1) drops the lowest set bit, i.e. the lane currently on the bus
  assign w_rem_clr = r_rem & (r_rem - mask_t'(1));

  // In IDLE the first lane is chosen straight from the inputs so mem_we rises right after accept
  assign w_enc_in   = w_idle ? bus.in_mask : w_rem_clr;
  assign w_src_data = w_idle ? bus.in_data : r_data;
  assign w_src_base = w_idle ? bus.in_addr : r_base;

  lane_prio_enc u_enc (
    .i_vec (w_enc_in),
    .o_idx (w_lane),
    .o_any (w_any)
  );

  always_comb begin
    w_lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_lane == i[LIDX_W-1:0]) w_lane_data = w_src_data[i*LANE_W +: LANE_W];
    end
  end

  assign w_lane_addr = w_src_base + addr_t'(w_lane);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_base      <= '0;
      r_rem       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_data <= bus.in_data;
            r_base <= bus.in_addr;
            r_rem  <= bus.in_mask;
            if (w_any) begin
              r_state     <= S_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_lane_addr;
              r_mem_wdata <= w_lane_data;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          if (w_hs) begin
            r_rem <= w_rem_clr;
            if (w_any) begin
              r_mem_addr  <= w_lane_addr;
              r_mem_wdata <= w_lane_data;
            end else begin
              r_mem_we <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.done      = (r_state == S_DONE);
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_vect_store_serializer.sv
// Bench for the vector store serializer: queue-based reference model plus directed scenarios.
module tb_vect_store_serializer;
  import vect_pkg::*;

  typedef struct {
    addr_t a;
    lane_t d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  vect_store_serializer_if bus();

  vect_store_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t   m_q[$];
  bit    m_busy = 1'b0;
  bit    m_done_due = 1'b0;

  addr_t log_a[$];
  lane_t log_d[$];
  int    done_cnt  = 0;
  int    stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the pending write list and the done obligation
  always @(negedge clk) begin
    bit  was_idle;
    wr_t w;
    if (!rst_n) begin
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      m_q.delete();
      m_busy = 1'b0;
      m_done_due = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, !m_busy);
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done_due);
      check("mem_we", bus.mem_we, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("mem_addr", bus.mem_addr, m_q[0].a);
        check("mem_wdata", bus.mem_wdata, m_q[0].d);
      end
      if (bus.mem_we && bus.mem_ready) begin
        log_a.push_back(bus.mem_addr);
        log_d.push_back(bus.mem_wdata);
      end
      if (bus.mem_we && !bus.mem_ready) stall_cnt++;
      if (bus.done) done_cnt++;

      was_idle = !m_busy;
      if (m_done_due) begin
        m_done_due = 1'b0;
        m_busy = 1'b0;
      end else if (m_q.size() != 0 && bus.mem_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done_due = 1'b1;
      end
      if (was_idle && bus.in_valid) begin
        m_busy = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          if (bus.in_mask[i]) begin
            w.a = addr_t'(bus.in_addr + i);
            w.d = lane_t'(bus.in_data >> (LANE_W * i));
            m_q.push_back(w);
          end
        end
        if (m_q.size() == 0) m_done_due = 1'b1;
      end
    end
  end

  task automatic send(input vec_t d, input addr_t a, input mask_t m);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_addr  = a;
    bus.in_mask  = m;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    check("send_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    check(name, bus.done, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_d.delete();
  endtask

  localparam vec_t VEC_A = {24'd2080, 24'd774, 24'd4018, 24'd1188, 24'd540, 24'd444};
  localparam vec_t VEC_B = {{5{24'h000000}}, 24'hFFFFF6};

  initial begin
    int    lane_vals[6];
    addr_t wrap_addr[6];
    int    cnt;
    int    dc;
    lane_vals = '{444, 540, 1188, 4018, 774, 2080};
    wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_addr   = '0;
    bus.in_mask   = '0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_mem_we", bus.mem_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full mask, memory always ready
    clear_logs();
    dc = done_cnt;
    send(VEC_A, 16'h0100, 6'b111111);
    cnt = 0;
    do begin
      @(negedge clk);
      if (!bus.in_ready) cnt++;
    end while (!bus.in_ready && cnt < 30);
    check("full_ready_low_cycles", cnt, 7);
    @(posedge clk); #1;
    check("full_nwrites", log_a.size(), 6);
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      check("full_addr", log_a[i], 16'h0100 + i);
      check("full_data", log_d[i], lane_vals[i]);
    end
    check("full_done_cnt", done_cnt - dc, 1);

    // Sparse mask: lanes 0, 2, 5
    clear_logs();
    send(VEC_A, 16'h0040, 6'b100101);
    wait_done("sparse_done");
    check("sparse_nwrites", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("sparse_a0", log_a[0], 16'h0040);
      check("sparse_d0", log_d[0], 444);
      check("sparse_a1", log_a[1], 16'h0042);
      check("sparse_d1", log_d[1], 1188);
      check("sparse_a2", log_a[2], 16'h0045);
      check("sparse_d2", log_d[2], 2080);
    end

    // Backpressure: memory stalls lane 1 for three cycles
    clear_logs();
    stall_cnt = 0;
    send(VEC_A, 16'h0200, 6'b111111);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_stalled_addr", bus.mem_addr, 16'h0201);
    check("bp_stalled_data", bus.mem_wdata, 540);
    bus.mem_ready = 1'b1;
    wait_done("bp_done");
    check("bp_stall_cycles", stall_cnt, 3);
    check("bp_nwrites", log_a.size(), 6);
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      check("bp_addr", log_a[i], 16'h0200 + i);
      check("bp_data", log_d[i], lane_vals[i]);
    end

    // Zero mask: no writes, done in the cycle after accept
    clear_logs();
    send(VEC_A, 16'h0010, 6'b000000);
    @(negedge clk);
    check("zero_done", bus.done, 1);
    check("zero_mem_we", bus.mem_we, 0);
    @(negedge clk);
    check("zero_done_pulse", bus.done, 0);
    check("zero_ready", bus.in_ready, 1);
    check("zero_nwrites", log_a.size(), 0);

    // Address wrap at the top of memory
    clear_logs();
    send(VEC_A, 16'hFFFE, 6'b111111);
    wait_done("wrap_done");
    check("wrap_nwrites", log_a.size(), 6);
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      check("wrap_addr", log_a[i], wrap_addr[i]);
    end

    // in_valid held high while busy; second vector waits for IDLE
    clear_logs();
    dc = done_cnt;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = VEC_A;
    bus.in_addr  = 16'h0300;
    bus.in_mask  = 6'b000011;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_data = VEC_B;
    bus.in_addr = 16'h0400;
    bus.in_mask = 6'b000001;
    @(negedge clk);
    check("hold_ready_low", bus.in_ready, 0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.in_ready && cnt < 50);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done("hold_done");
    check("hold_nwrites", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("hold_a0", log_a[0], 16'h0300);
      check("hold_d0", log_d[0], 444);
      check("hold_a1", log_a[1], 16'h0301);
      check("hold_d1", log_d[1], 540);
      check("hold_a2", log_a[2], 16'h0400);
      check("hold_d2", log_d[2], 24'hFFFFF6);
    end
    check("hold_done_cnt", done_cnt - dc, 2);

    // Asynchronous reset after lane 2 is written
    clear_logs();
    dc = done_cnt;
    send(VEC_A, 16'h0500, 6'b111111);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_mem_we", bus.mem_we, 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_mem_wdata", bus.mem_wdata, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_done", bus.done, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_nwrites", log_a.size(), 3);
    check("arst_no_done", done_cnt - dc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "simulation timeout");
  end
endmodule
